// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI interface.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FRM1 = 3'd1,
        GAP  = 3'd2,
        FRM2 = 3'd3,
        DONE = 3'd4
    } a2d_state_t;

    // Divider preload: first SCLK fall lands 10 clks after SS_n falls.
    localparam logic [4:0]  SCLK_PRELOAD = 5'b10110;
    // SS_n high time between the two frames of a conversion.
    localparam int          GAP_CLKS     = 4;
    localparam logic [10:0] CMD_PAD      = 11'h000;

    // Command word for the ADC128S-style converter: channel in bits [13:11].
    function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
        return {2'b00, ch, CMD_PAD};
    endfunction

endpackage

// File: rtl/a2d_intf_spi_mstr16.sv
// 16-bit SPI master: SCLK idles high, MOSI changes on falls, MISO sampled on rises.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    localparam logic [DIV_W-1:0] DIV_ALL1 = '1;
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_ALL1 >> 1;
    // Keep 10 clks from SS_n fall to first SCLK fall for any divider width.
    localparam logic [DIV_W-1:0] PRELOAD  = (DIV_W == 5) ? DIV_W'(SCLK_PRELOAD)
                                                         : DIV_ALL1 - DIV_W'(9);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [15:0]      shft_reg, shft_next;
    logic [4:0]       rise_cnt_reg, rise_cnt_next;
    logic             miso_smpl_reg, miso_smpl_next;
    logic             ss_n_reg, ss_n_next;
    logic             sclk_reg, sclk_next;
    logic             mosi_reg, mosi_next;
    logic             rise_evt, fall_evt, term_evt, shift_evt;

    // Frame engine: divider, rise/fall events, shift register and chip-select.
    always_comb begin
        rise_evt       = !ss_n_reg && (div_reg == DIV_RISE);
        fall_evt       = !ss_n_reg && (div_reg == DIV_ALL1);
        // The fall after the 16th rise never reaches the pin; it ends the frame.
        term_evt       = fall_evt && (rise_cnt_reg == 5'd16);
        // The front-porch fall (no rise yet) does not shift.
        shift_evt      = fall_evt && (rise_cnt_reg != 5'd0);
        div_next       = div_reg;
        shft_next      = shft_reg;
        rise_cnt_next  = rise_cnt_reg;
        miso_smpl_next = miso_smpl_reg;
        ss_n_next      = ss_n_reg;
        if (ss_n_reg) begin
            // A write while a frame is running is ignored.
            if (wrt) begin
                div_next      = PRELOAD;
                shft_next     = cmd;
                rise_cnt_next = 5'd0;
                ss_n_next     = 1'b0;
            end
        end else begin
            div_next = div_reg + DIV_W'(1);
            if (rise_evt) begin
                miso_smpl_next = MISO;
                rise_cnt_next  = rise_cnt_reg + 5'd1;
            end
            if (shift_evt) begin
                shft_next = {shft_reg[14:0], miso_smpl_reg};
            end
            if (term_evt) begin
                ss_n_next = 1'b1;
            end
        end
        // Pins are registered so SS_n edges cannot glitch SCLK or MOSI.
        sclk_next = ss_n_next | div_next[DIV_W-1];
        mosi_next = !ss_n_next & shft_next[15];
    end

    // Frame engine state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg       <= '0;
            shft_reg      <= '0;
            rise_cnt_reg  <= '0;
            miso_smpl_reg <= 1'b0;
            ss_n_reg      <= 1'b1;
            sclk_reg      <= 1'b1;
            mosi_reg      <= 1'b0;
        end else begin
            div_reg       <= div_next;
            shft_reg      <= shft_next;
            rise_cnt_reg  <= rise_cnt_next;
            miso_smpl_reg <= miso_smpl_next;
            ss_n_reg      <= ss_n_next;
            sclk_reg      <= sclk_next;
            mosi_reg      <= mosi_next;
        end
    end

    // done is a one-cycle strobe on the terminal edge; rd_data is the fully
    // shifted word as it is being written, valid only alongside done.
    assign done    = term_evt;
    assign rd_data = {shft_reg[14:0], miso_smpl_reg};
    assign SS_n    = ss_n_reg;
    assign SCLK    = sclk_reg;
    assign MOSI    = mosi_reg;

endmodule

// File: rtl/a2d_intf.sv
// Two-frame conversion sequencer for the 8-channel 12-bit A2D.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    input  logic        MISO,
    output logic [11:0] A2D_res,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    a2d_state_t  state_reg, state_next;
    logic [2:0]  gap_cnt_reg, gap_cnt_next;
    logic [2:0]  chnnl_reg, chnnl_next;
    logic [15:0] cmd_reg, cmd_next;
    logic        wrt_reg, wrt_next;
    logic [11:0] res_reg, res_next;
    logic        cmplt_reg, cmplt_next;
    logic        accept, set_res;
    logic        frm_done;
    logic [15:0] rd_data;
    logic        unused_rd_hi;

    spi_mstr16 #(.DIV_W(SCLK_DIV_W)) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (wrt_reg),
        .cmd     (cmd_reg),
        .MISO    (MISO),
        .done    (frm_done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    // Upper result bits are the converter's leading zeros.
    assign unused_rd_hi = ^rd_data[15:12];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic. DONE also accepts a start so a request arriving in the
    // cycle cnv_cmplt rises is not lost.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (strt_cnv) state_next = FRM1;
            FRM1:    if (frm_done) state_next = GAP;
            GAP:     if (gap_cnt_reg == 3'(GAP_CLKS - 2)) state_next = FRM2;
            FRM2:    if (frm_done) state_next = DONE;
            DONE:    state_next = strt_cnv ? FRM1 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: start acceptance, frame writes and result capture.
    always_comb begin
        accept       = ((state_reg == IDLE) || (state_reg == DONE)) && strt_cnv;
        set_res      = (state_reg == FRM2) && frm_done;
        wrt_next     = accept || ((state_reg == GAP) && (state_next == FRM2));
        chnnl_next   = accept ? chnnl : chnnl_reg;
        cmd_next     = a2d_cmd(chnnl_next);
        gap_cnt_next = (state_reg == GAP) ? gap_cnt_reg + 3'd1 : 3'd0;
        res_next     = set_res ? rd_data[11:0] : res_reg;
        cmplt_next   = set_res | (cmplt_reg & !accept);
    end

    // Channel latch, command, GAP counter and result/complete registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_reg <= '0;
            chnnl_reg   <= '0;
            cmd_reg     <= '0;
            wrt_reg     <= 1'b0;
            res_reg     <= '0;
            cmplt_reg   <= 1'b0;
        end else begin
            gap_cnt_reg <= gap_cnt_next;
            chnnl_reg   <= chnnl_next;
            cmd_reg     <= cmd_next;
            wrt_reg     <= wrt_next;
            res_reg     <= res_next;
            cmplt_reg   <= cmplt_next;
        end
    end

    assign A2D_res   = res_reg;
    assign cnv_cmplt = cmplt_reg;

endmodule

// File: doc/a2d_intf.md
# a2d_intf

Upstream stage of `motion_cntrl`. It turns `strt_cnv` and `chnnl` into an SPI exchange with the 8-channel, 12-bit IR-sensor A2D converter (ADC128S-style). It returns the 12-bit result on `A2D_res` and flags completion with `cnv_cmplt`. The block sits between the motion controller and the chip pins `SS_n`, `SCLK`, `MOSI` and `MISO`.

## Interface
Parameters:
- `SCLK_DIV_W`, default 5: width of the SCLK divider; SCLK period is 2**SCLK_DIV_W clk cycles (32).

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `strt_cnv`  in  1  start-conversion pulse from `motion_cntrl`
- `chnnl`  in  3  A2D channel to convert; sampled with `strt_cnv`
- `MISO`  in  1  serial data from the A2D
- `A2D_res`  out  12  last completed conversion result
- `cnv_cmplt`  out  1  result valid; held until next accepted `strt_cnv`
- `SS_n`  out  1  active-low A2D select
- `SCLK`  out  1  serial clock; idles high
- `MOSI`  out  1  serial data to the A2D (MSB first)

## Operation
- Reset values: `SS_n`=1, `SCLK`=1, `MOSI`=0, `cnv_cmplt`=0, `A2D_res`=0, state IDLE.
- A conversion consists of two 16-bit frames:
  - Frame 1 sends the command word {2'b00, chnnl, 11'h000}; received data is discarded.
  - Frame 2 sends the same command word; the low 12 bits received become `A2D_res`.
- FSM states: IDLE, FRM1, GAP, FRM2, DONE.
  - IDLE --strt_cnv--> FRM1: latch `chnnl`, load command into the shift register, clear `cnv_cmplt`.
  - FRM1 --frame_done--> GAP.
  - GAP --4 clks--> FRM2: reload command.
  - FRM2 --frame_done--> DONE: `A2D_res` <= shft[11:0].
  - DONE --> IDLE: set `cnv_cmplt`.
- Frame engine:
  - Divider `div` is preloaded to 5'b10110 at frame start and free-runs, wrapping 31->0.
  - `SCLK` = div[4] while `SS_n` is low, otherwise 1.
  - Rise (div 15->16): capture `MISO` into `miso_smpl`.
  - Fall (div 31->0):
    - The first fall of a frame is front porch and does not shift.
    - Falls 2..16 shift: shft <= {shft[14:0], miso_smpl}.
    - A 5-bit count tracks the rises.
  - Terminal event: div==31 after the 16th rise. It performs the 16th shift, raises `SS_n`, and suppresses the fall, so `SCLK` stays high. This is frame_done.
  - `MOSI` = shft[15] while `SS_n` is low.
- A `strt_cnv` outside IDLE is ignored; the latched channel and the frame in progress are unaffected.
- `rst` mid-frame returns every output to its reset value on the next edge; no partial result is written.
- `chnnl` changes after acceptance have no effect until the next accepted `strt_cnv`.

## Timing
- Edge 0 samples `strt_cnv`. Relative to that edge:
  - `SS_n` low for edges 1..522 (frame 1).
  - `SS_n` high for 4 cycles (GAP).
  - `SS_n` low for 522 cycles (frame 2).
  - `cnv_cmplt` rises at edge 1049.
- Within a frame:
  - First SCLK fall 10 clks after `SS_n` falls.
  - Rises at offsets 26 + 32k, k = 0..15.
  - `SS_n` rises 16 clks after the 16th rise.
- SCLK: 50% duty, period 32 clks; no glitches on `SS_n` edges.
- `A2D_res` and `cnv_cmplt` update in the same cycle. `A2D_res` is stable while `cnv_cmplt`=1.
- Back-to-back: `strt_cnv` in the cycle `cnv_cmplt` rises is accepted. `cnv_cmplt` drops the next cycle and `SS_n` falls one cycle after that.

## Structure
- Shared package `a2d_pkg`:
  - `a2d_state_t` enum (IDLE, FRM1, GAP, FRM2, DONE).
  - Localparams `SCLK_PRELOAD` = 5'b10110, `GAP_CLKS` = 4, `CMD_PAD` = 11'h000.
- One sub-module: `spi_mstr16`, a 16-bit SPI master.
  - Inputs: `wrt`, `cmd[15:0]`.
  - Outputs: `done`, `rd_data[15:0]`, `SS_n`, `SCLK`, `MOSI`.
  - The frame engine above lives in it.
- `a2d_intf` holds the two-frame FSM, channel latch, GAP counter and the result/complete registers.

## Test plan
- Reset: hold `rst` 2 cycles -> `SS_n`=1, `SCLK`=1, `cnv_cmplt`=0, `A2D_res`=12'h000; no SCLK toggles while idle.
- Channel 5, A2D model returns 16'h0ABC in frame 2 -> MOSI frames both 16'h2800, `A2D_res`=12'hABC, `cnv_cmplt` rises at edge 1049.
- SCLK shape during frame 1 -> exactly 16 rises, period 32, first fall 10 clks after `SS_n` falls, `SS_n` high for 4 clks between frames.
- `strt_cnv` with channel 3 pulsed at edge 300 of a channel-0 conversion -> ignored; both command words remain 16'h0000, single `cnv_cmplt`.
- `rst` asserted mid-frame 2 -> next edge `SS_n`=1, `SCLK`=1, `cnv_cmplt`=0, `A2D_res` unchanged from reset value 0; a subsequent `strt_cnv` performs a full conversion.
- Back-to-back: `strt_cnv` (channel 7) in the `cnv_cmplt` cycle -> `cnv_cmplt` low next cycle, `SS_n` low the cycle after, command 16'h3800.
